// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and latency constants for seq_alu.
// Optional build macro: MUL_RADIX4_EN selects the radix-4 Booth multiplier.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_MUL  = 3'd1;
   localparam state_t ST_DIV  = 3'd2;
   localparam state_t ST_FIX  = 3'd3;
   localparam state_t ST_DONE = 3'd4;

`ifdef MUL_RADIX4_EN
   localparam int MUL_BITS = 2;
`else
   localparam int MUL_BITS = 1;
`endif

   // Start-to-done latency in cycles for the default 32-bit build.
   localparam int DEF_WIDTH  = 32;
   localparam int MUL_CYCLES = DEF_WIDTH / MUL_BITS + 1;
   localparam int DIV_CYCLES = DEF_WIDTH + 2;

   function automatic int mul_latency(input int w);
      return w / MUL_BITS + 1;
   endfunction

   function automatic int div_latency(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/seq_alu_div.sv
// seq_div_core: signed restoring divider on operand magnitudes.
// Sign correction is combinational on the outputs, sampled in FIX.
module seq_div_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             last
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] d;
   logic             neg_q;
   logic             neg_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      r_sh = {r, q[WIDTH-1]};
      diff = r_sh - {1'b0, d};
   end

   // Load magnitudes on start, then one quotient bit per step.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q     <= '0;
         r     <= '0;
         d     <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
      end else if (load) begin
         q     <= a[WIDTH-1] ? -a : a;
         d     <= b[WIDTH-1] ? -b : b;
         r     <= '0;
         neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r <= a[WIDTH-1];
         cnt   <= CW'(WIDTH);
      end else if (step) begin
         if (!diff[WIDTH]) begin
            r <= diff[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
         end else begin
            r <= r_sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
         end
         cnt <= cnt - 1'b1;
      end
   end

   assign quot = neg_q ? -q : q;
   assign rem  = neg_r ? -r : r;
   assign last = (cnt == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, Booth multiply and restoring divide.
// Build macro MUL_RADIX4_EN switches mul to radix-4 Booth (WIDTH/2 steps).
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 5
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [OPW-1:0]     opcode,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] C,
   output logic               div_by_zero
);

   localparam int SW     = $clog2(WIDTH);
   localparam int MSTEPS = WIDTH / MUL_BITS;
   localparam int CNTW   = SW + 1;

   state_t                 state;
   logic [OPW-1:0]         op_q;
   logic [2*WIDTH-1:0]     res;
   logic                   dz_pend;
   logic [CNTW-1:0]        cnt;

   logic signed [WIDTH+1:0] acc;
   logic [WIDTH-1:0]        mq;
   logic                    q1;
   logic [WIDTH-1:0]        m;

   logic [WIDTH-1:0]        alu_lo;
   logic [SW-1:0]           s;
   logic                    big;
   logic [2*WIDTH-1:0]      dbl;
   logic [2*WIDTH-1:0]      rr;
   logic [2*WIDTH-1:0]      rl;

   logic signed [WIDTH+1:0]   mext;
   logic signed [WIDTH+1:0]   addend;
   logic signed [WIDTH+1:0]   sum;
   logic signed [2*WIDTH+2:0] sh;

   logic                    is_mul;
   logic                    is_div;
   logic                    b_zero;
   logic                    div_load;
   logic [WIDTH-1:0]        quot;
   logic [WIDTH-1:0]        rem;
   logic                    div_last;

   assign is_mul   = (opcode == OPW'(OP_MUL));
   assign is_div   = (opcode == OPW'(OP_DIV));
   assign b_zero   = (B == '0);
   assign div_load = (state == ST_IDLE) && start && is_div && !b_zero;

   // Single-cycle result from the live operands, captured on the start edge.
   always_comb begin
      s      = B[SW-1:0];
      big    = |B[WIDTH-1:SW];
      dbl    = {A, A};
      rr     = dbl >> s;
      rl     = dbl << s;
      alu_lo = '0;
      case (opcode)
         OPW'(OP_ADD),
         OPW'(OP_ADDI): alu_lo = A + B;
         OPW'(OP_SUB):  alu_lo = A - B;
         OPW'(OP_AND),
         OPW'(OP_ANDI): alu_lo = A & B;
         OPW'(OP_OR),
         OPW'(OP_ORI):  alu_lo = A | B;
         OPW'(OP_SHR):  alu_lo = big ? '0 : A >> s;
         OPW'(OP_SHRA): alu_lo = big ? {WIDTH{A[WIDTH-1]}}
                                     : WIDTH'($signed(A) >>> s);
         OPW'(OP_SHL):  alu_lo = big ? '0 : A << s;
         OPW'(OP_ROR):  alu_lo = rr[WIDTH-1:0];
         OPW'(OP_ROL):  alu_lo = rl[2*WIDTH-1:WIDTH];
         OPW'(OP_NEG):  alu_lo = -A;
         OPW'(OP_NOT):  alu_lo = ~A;
         default:       alu_lo = '0;
      endcase
   end

   // One Booth recoding step: add the selected multiple, then shift.
   always_comb begin
      mext   = {{2{m[WIDTH-1]}}, m};
      addend = '0;
`ifdef MUL_RADIX4_EN
      case ({mq[1:0], q1})
         3'b001, 3'b010: addend = mext;
         3'b011:         addend = mext <<< 1;
         3'b100:         addend = -(mext <<< 1);
         3'b101, 3'b110: addend = -mext;
         default:        addend = '0;
      endcase
      sum = acc + addend;
      sh  = {sum, mq, q1};
      sh  = sh >>> 2;
`else
      case ({mq[0], q1})
         2'b01:   addend = mext;
         2'b10:   addend = -mext;
         default: addend = '0;
      endcase
      sum = acc + addend;
      sh  = {sum, mq, q1};
      sh  = sh >>> 1;
`endif
   end

   seq_div_core #(.WIDTH(WIDTH)) u_div (
      .clk  (clk),
      .clr  (clr),
      .load (div_load),
      .step (state == ST_DIV),
      .a    (A),
      .b    (B),
      .quot (quot),
      .rem  (rem),
      .last (div_last)
   );

   // Control FSM, Booth datapath and registered result/handshake.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= ST_IDLE;
         op_q        <= '0;
         res         <= '0;
         dz_pend     <= 1'b0;
         cnt         <= '0;
         acc         <= '0;
         mq          <= '0;
         q1          <= 1'b0;
         m           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         C           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state == ST_MUL) || (state == ST_DIV) ||
                 (state == ST_FIX);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q        <= opcode;
                  m           <= A;
                  mq          <= B;
                  acc         <= '0;
                  q1          <= 1'b0;
                  res         <= {{WIDTH{1'b0}}, alu_lo};
                  dz_pend     <= 1'b0;
                  div_by_zero <= 1'b0;
                  cnt         <= CNTW'(MSTEPS - 1);
                  if (is_mul) begin
                     state <= ST_MUL;
                  end else if (is_div && !b_zero) begin
                     state <= ST_DIV;
                  end else if (is_div) begin
                     res     <= {A, {WIDTH{1'b1}}};
                     dz_pend <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               acc <= sh[2*WIDTH+2:WIDTH+1];
               mq  <= sh[WIDTH:1];
               q1  <= sh[0];
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= ST_DONE;
            end
            ST_DIV: begin
               if (div_last) state <= ST_FIX;
            end
            ST_FIX: begin
               res   <= {rem, quot};
               state <= ST_DONE;
            end
            ST_DONE: begin
               C           <= (op_q == OPW'(OP_MUL)) ?
                              {acc[WIDTH-1:0], mq} : res;
               done        <= 1'b1;
               div_by_zero <= dz_pend;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and model-checked bench for seq_alu.
// Expected results queue up at start and are matched when done pulses.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef MUL_RADIX4_EN
   localparam int MLAT = W / 2 + 1;
`else
   localparam int MLAT = W + 1;
`endif
   localparam int DLAT = W + 2;

   logic           clk = 1'b0;
   logic           clr;
   logic           start;
   logic [4:0]     opcode;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*W-1:0] C;
   logic           dz;

   typedef struct packed {
      logic [63:0] c;
      logic        dz;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   seq_alu #(.WIDTH(W), .OPW(5)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .opcode      (opcode),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .C           (C),
      .div_by_zero (dz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for done starting just after the start edge.
   task automatic wait_done(output int cyc, output bit seen,
                            input bool_chk_busy);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bool_chk_busy && cyc == 1) chk("busy_hi", {63'd0, busy}, 64'd1);
         if (done) seen = 1'b1;
      end
   endtask

   task automatic run(input string tag, input logic [4:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] ec, input logic edz,
                      input int lat);
      exp_t e;
      int   cyc;
      bit   seen;
      @(negedge clk);
      opcode = op;
      A      = a;
      B      = b;
      start  = 1'b1;
      sb.push_back('{c: ec, dz: edz, lat: 8'(lat)});
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      A      = $urandom;
      B      = $urandom;
      opcode = 5'b10101;
      chk({tag, ".dz_clr"}, {63'd0, dz}, 64'd0);
      wait_done(cyc, seen, lat > 1);
      chk({tag, ".done"}, {63'd0, seen}, 64'd1);
      e = sb.pop_front();
      if (seen) begin
         chk({tag, ".lat"}, 64'(cyc), 64'(e.lat));
         chk({tag, ".C"}, C, e.c);
         chk({tag, ".dz"}, {63'd0, dz}, {63'd0, e.dz});
         chk({tag, ".busy_lo"}, {63'd0, busy}, 64'd0);
         @(negedge clk);
         chk({tag, ".pulse"}, {63'd0, done}, 64'd0);
      end
   endtask

   initial begin
      int     cyc;
      bit     seen;
      int     ndone;
      longint pa;
      longint pb;
      int     sa;
      int     dv;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      exp_t   e;

      clr    = 1'b1;
      start  = 1'b0;
      opcode = '0;
      A      = '0;
      B      = '0;
      repeat (2) @(negedge clk);
      chk("rst.busy", {63'd0, busy}, 64'd0);
      chk("rst.done", {63'd0, done}, 64'd0);
      chk("rst.C", C, 64'd0);
      chk("rst.dz", {63'd0, dz}, 64'd0);
      clr = 1'b0;

      run("add", OP_ADD, 32'h7FFFFFFF, 32'd1, 64'h00000000_80000000, 0, 1);
      run("sub", OP_SUB, 32'd3, 32'd5, 64'h00000000_FFFFFFFE, 0, 1);
      run("and", OP_ANDI, 32'hF0F0_1234, 32'h0FF0_00FF, 64'h0000_0000_00F0_0034, 0, 1);
      run("or", OP_ORI, 32'hF000_0001, 32'h0000_0F00, 64'h0000_0000_F000_0F01, 0, 1);
      run("neg", OP_NEG, 32'd1, 32'd0, 64'h0000_0000_FFFF_FFFF, 0, 1);
      run("not", OP_NOT, 32'h0000_FFFF, 32'd0, 64'h0000_0000_FFFF_0000, 0, 1);
      run("ror", OP_ROR, 32'd1, 32'd1, 64'h0000_0000_8000_0000, 0, 1);
      run("rol", OP_ROL, 32'h8000_0001, 32'd4, 64'h0000_0000_0000_0018, 0, 1);
      run("shra", OP_SHRA, 32'h8000_0000, 32'd40, 64'h0000_0000_FFFF_FFFF, 0, 1);
      run("shra4", OP_SHRA, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000, 0, 1);
      run("shl32", OP_SHL, 32'd1, 32'd32, 64'd0, 0, 1);
      run("shl", OP_SHL, 32'd1, 32'd31, 64'h0000_0000_8000_0000, 0, 1);
      run("shr", OP_SHR, 32'h8000_0000, 32'd31, 64'd1, 0, 1);
      run("badop", 5'b11111, 32'd9, 32'd9, 64'd0, 0, 1);

      run("mul", OP_MUL, -32'sd3, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 0, MLAT);
      run("mulmin", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 0, MLAT);
      run("div", OP_DIV, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, DLAT);
      run("divmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 0, DLAT);
      run("div0", OP_DIV, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1, 1);
      run("after0", OP_ADD, 32'd1, 32'd1, 64'd2, 0, 1);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom;
         pa = longint'($signed(ra));
         pb = longint'($signed(rb));
         run("rmul", OP_MUL, ra, rb, 64'(pa * pb), 0, MLAT);
         rb = $urandom_range(1, 1000);
         if (i == 1) rb = -rb;
         sa = ra;
         dv = rb;
         run("rdiv", OP_DIV, ra, rb,
             {32'(sa % dv), 32'(sa / dv)}, 0, DLAT);
      end

      // Abort a multiply with clr: no done, outputs clear at once.
      @(negedge clk);
      opcode = OP_MUL;
      A      = 32'd11;
      B      = 32'd13;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      clr = 1'b1;
      #1;
      chk("clr.busy", {63'd0, busy}, 64'd0);
      chk("clr.C", C, 64'd0);
      chk("clr.done", {63'd0, done}, 64'd0);
      @(negedge clk);
      clr   = 1'b0;
      ndone = 0;
      repeat (MLAT + 4) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("clr.nodone", 64'(ndone), 64'd0);
      run("add23", OP_ADD, 32'd2, 32'd3, 64'd5, 0, 1);

      // A second start while busy must be dropped.
      @(negedge clk);
      opcode = OP_MUL;
      A      = -32'sd3;
      B      = 32'd7;
      start  = 1'b1;
      sb.push_back('{c: 64'hFFFFFFFF_FFFFFFEB, dz: 1'b0, lat: 8'(MLAT)});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      opcode = OP_ADD;
      A      = 32'd2;
      B      = 32'd3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, seen, 1'b0);
      cyc = cyc + 4;
      chk("ign.done", {63'd0, seen}, 64'd1);
      e = sb.pop_front();
      chk("ign.lat", 64'(cyc), 64'(e.lat));
      chk("ign.C", C, e.c);
      ndone = 0;
      repeat (2 * MLAT) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("ign.nodone", 64'(ndone), 64'd0);
      chk("ign.C_hold", C, 64'hFFFFFFFF_FFFFFFEB);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
